// File: rtl/pe_word_collector_if.sv
// Bus bundle between a PE output link driver and the word collector:
// word stream, clear, readback port and status.
interface pe_word_collector_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3
);
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word;
  logic                             i_valid;
  logic                             i_clear;
  logic [ADDR_WIDTH-1:0]            rd_addr;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_valid;
  logic [ADDR_WIDTH:0]              o_count;
  logic                             o_busy;
  logic                             o_full;
  logic                             o_dup;

  modport master (
    output i_word, i_valid, i_clear, rd_addr,
    input  rd_data, rd_valid, o_count, o_busy, o_full, o_dup
  );

  modport slave (
    input  i_word, i_valid, i_clear, rd_addr,
    output rd_data, rd_valid, o_count, o_busy, o_full, o_dup
  );
endinterface

// File: rtl/pe_word_collector.sv
// Captures PE output words once they have been stable for SORT_CYCLES cycles into an
// address-indexed register file, tracking fill state, duplicates and completion.
module pe_word_collector #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 3,
  parameter int SORT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  pe_word_collector_if.slave bus
);
  localparam int WORD_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CW         = ADDR_WIDTH + 1;
  localparam int SW         = $clog2(SORT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(SORT_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [WORD_WIDTH-1:0] prev_word_q, prev_word_d;
  logic                  prev_valid_q, prev_valid_d;
  logic                  armed_q, armed_d;
  logic [SW-1:0]         stab_q, stab_d;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  dup_q, dup_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  stable;
  logic                  capture;

  assign w_addr = bus.i_word[WORD_WIDTH-1:DATA_WIDTH];
  assign w_data = bus.i_word[DATA_WIDTH-1:0];

  always_comb begin
    stable = bus.i_valid && prev_valid_q && (bus.i_word == prev_word_q);

    if (!bus.i_valid) begin
      stab_d = '0;
    end else if (stable) begin
      stab_d = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1);
    end else begin
      stab_d = SW'(1);
    end

    // One capture per stable run: a run already sitting at the limit does not refire.
    // armed_q blocks a capture on the first edge after reset release.
    capture = armed_q && bus.i_valid && (stab_d == STAB_MAX) &&
              !(stable && (stab_q == STAB_MAX));

    prev_word_d  = bus.i_word;
    prev_valid_d = bus.i_valid;
    armed_d      = 1'b1;
    state_d      = state_q;
    mem_d        = mem_q;
    filled_d     = filled_q;
    count_d      = count_q;
    dup_d        = dup_q;
    rd_data_d    = mem_q[bus.rd_addr];
    rd_valid_d   = filled_q[bus.rd_addr];

    if (bus.i_clear) begin
      state_d  = ST_IDLE;
      filled_d = '0;
      count_d  = '0;
      dup_d    = 1'b0;
      stab_d   = '0;
    end else if (capture) begin
      if (state_q == ST_DONE) begin
        dup_d = 1'b1;
      end else begin
        mem_d[w_addr]    = w_data;
        filled_d[w_addr] = 1'b1;
        if (filled_q[w_addr]) begin
          dup_d   = 1'b1;
          state_d = ST_COLLECT;
        end else begin
          count_d = count_q + CW'(1);
          state_d = (count_d == COUNT_MAX) ? ST_DONE : ST_COLLECT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      stab_q       <= '0;
      state_q      <= ST_IDLE;
      filled_q     <= '0;
      count_q      <= '0;
      dup_q        <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      prev_word_q  <= prev_word_d;
      prev_valid_q <= prev_valid_d;
      armed_q      <= armed_d;
      stab_q       <= stab_d;
      state_q      <= state_d;
      filled_q     <= filled_d;
      count_q      <= count_d;
      dup_q        <= dup_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.o_count  = count_q;
  assign bus.o_busy   = (state_q == ST_COLLECT);
  assign bus.o_full   = (state_q == ST_DONE);
  assign bus.o_dup    = dup_q;
endmodule

// File: tb/tb_pe_word_collector.sv
// Drives two collectors (SORT_CYCLES 1 and 3) with identical stimulus and checks both
// against a run-length based reference model of the capture, fill and readback rules.
module tb_pe_word_collector;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] drv_word    = '0;
  logic       drv_valid   = 1'b0;
  logic       drv_clear   = 1'b0;
  logic [2:0] drv_rd_addr = '0;

  pe_word_collector_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3)) bus_a ();
  pe_word_collector_if #(.ADDR_WIDTH(3), .DATA_WIDTH(3)) bus_b ();

  assign bus_a.i_word  = drv_word;
  assign bus_a.i_valid = drv_valid;
  assign bus_a.i_clear = drv_clear;
  assign bus_a.rd_addr = drv_rd_addr;
  assign bus_b.i_word  = drv_word;
  assign bus_b.i_valid = drv_valid;
  assign bus_b.i_clear = drv_clear;
  assign bus_b.rd_addr = drv_rd_addr;

  pe_word_collector #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .SORT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  pe_word_collector #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .SORT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Observed outputs packed as {rd_data, rd_valid, count, busy, full, dup}.
  logic [10:0] obs_vec [2];
  logic [2:0]  obs_rd  [2];
  logic        obs_rv  [2];
  logic [3:0]  obs_cnt [2];
  logic        obs_full[2];
  logic        obs_busy[2];
  logic        obs_dup [2];
  assign obs_vec[0] = {bus_a.rd_data, bus_a.rd_valid, bus_a.o_count, bus_a.o_busy, bus_a.o_full, bus_a.o_dup};
  assign obs_vec[1] = {bus_b.rd_data, bus_b.rd_valid, bus_b.o_count, bus_b.o_busy, bus_b.o_full, bus_b.o_dup};
  assign obs_rd[0] = bus_a.rd_data;   assign obs_rd[1] = bus_b.rd_data;
  assign obs_rv[0] = bus_a.rd_valid;  assign obs_rv[1] = bus_b.rd_valid;
  assign obs_cnt[0] = bus_a.o_count;  assign obs_cnt[1] = bus_b.o_count;
  assign obs_full[0] = bus_a.o_full;  assign obs_full[1] = bus_b.o_full;
  assign obs_busy[0] = bus_a.o_busy;  assign obs_busy[1] = bus_b.o_busy;
  assign obs_dup[0] = bus_a.o_dup;    assign obs_dup[1] = bus_b.o_dup;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one copy per DUT.
  logic [2:0] m_mem    [2][8];
  logic       m_filled [2][8];
  int         m_count  [2];
  logic       m_dup    [2];
  int         m_run    [2];
  logic [2:0] m_rd_data[2];
  logic       m_rd_valid[2];
  logic [5:0] m_prev_word;
  logic       m_prev_valid;

  function automatic int s_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [10:0] exp_vec(input int k);
    logic full, busy;
    full = (m_count[k] == 8);
    busy = (m_count[k] > 0) && !full;
    return {m_rd_data[k], m_rd_valid[k], 4'(m_count[k]), busy, full, m_dup[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[k][i]    = '0;
        m_filled[k][i] = 1'b0;
      end
      m_count[k] = 0; m_dup[k] = 1'b0; m_run[k] = 0;
      m_rd_data[k] = '0; m_rd_valid[k] = 1'b0;
    end
    m_prev_word  = '0;
    m_prev_valid = 1'b0;
  endtask

  // A capture fires when the current run of identical valid words reaches exactly S.
  task automatic model_edge();
    int  a, d;
    bit  cont;
    a    = int'(drv_word) >> 3;
    d    = int'(drv_word) & 7;
    cont = drv_valid && m_prev_valid && (drv_word == m_prev_word);
    for (int k = 0; k < 2; k++) begin
      m_rd_data[k]  = m_mem[k][drv_rd_addr];
      m_rd_valid[k] = m_filled[k][drv_rd_addr];
      m_run[k] = !drv_valid ? 0 : (cont ? m_run[k] + 1 : 1);
      if (drv_clear) begin
        for (int i = 0; i < 8; i++) m_filled[k][i] = 1'b0;
        m_count[k] = 0; m_dup[k] = 1'b0; m_run[k] = 0;
      end else if (drv_valid && m_run[k] == s_of(k)) begin
        if (m_count[k] == 8) begin
          m_dup[k] = 1'b1;
        end else begin
          if (m_filled[k][a]) m_dup[k] = 1'b1;
          else m_count[k]++;
          m_mem[k][a]    = 3'(d);
          m_filled[k][a] = 1'b1;
        end
      end
    end
    m_prev_word  = drv_word;
    m_prev_valid = drv_valid;
  endtask

  task automatic step(input logic [5:0] w, input logic v, input logic c, input logic [2:0] ra);
    @(negedge clk);
    drv_word = w; drv_valid = v; drv_clear = c; drv_rd_addr = ra;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_vec[k] !== 11'd0) begin
        n_err++;
        $display("FAIL reset dut%0d: got %b expected 0", k, obs_vec[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single_capture();
    step(6'b000000, 1'b0, 1'b0, 3'd0);
    step(6'b000101, 1'b1, 1'b0, 3'd0);
    n_vec++;
    if (obs_cnt[0] !== 4'd1 || obs_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_capture count/busy: got %0d/%0d expected 1/1", obs_cnt[0], obs_busy[0]);
    end
    step(6'b000000, 1'b0, 1'b0, 3'd0);
    n_vec++;
    if (obs_rd[0] !== 3'b101 || obs_rv[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_capture readback: got %b/%b expected 101/1", obs_rd[0], obs_rv[0]);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_vec[k] !== exp_vec(k)) begin
        n_err++;
        $display("FAIL single_capture dut%0d: got %b expected %b", k, obs_vec[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_stability();
    step(6'b000000, 1'b0, 1'b1, 3'd0);
    repeat (2) step(6'b011110, 1'b1, 1'b0, 3'd0);
    repeat (2) step(6'b100001, 1'b1, 1'b0, 3'd0);
    n_vec++;
    if (obs_cnt[1] !== 4'd0) begin
      n_err++;
      $display("FAIL stability early_count: got %0d expected 0", obs_cnt[1]);
    end
    step(6'b100001, 1'b1, 1'b0, 3'd0);
    n_vec++;
    if (obs_cnt[1] !== 4'd1) begin
      n_err++;
      $display("FAIL stability count: got %0d expected 1", obs_cnt[1]);
    end
    step(6'b000000, 1'b0, 1'b0, 3'b100);
    n_vec++;
    if (obs_rd[1] !== 3'b001 || obs_rv[1] !== 1'b1) begin
      n_err++;
      $display("FAIL stability readback: got %b/%b expected 001/1", obs_rd[1], obs_rv[1]);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_vec[k] !== exp_vec(k)) begin
        n_err++;
        $display("FAIL stability dut%0d: got %b expected %b", k, obs_vec[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_fill_done();
    logic [2:0] av;
    step(6'b000000, 1'b0, 1'b1, 3'd0);
    for (int a = 0; a < 8; a++) begin
      av = 3'(a);
      repeat (3) step({av, av}, 1'b1, 1'b0, 3'd0);
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_full[k] !== 1'b1 || obs_cnt[k] !== 4'd8) begin
        n_err++;
        $display("FAIL fill_done dut%0d full/count: got %0d/%0d expected 1/8", k, obs_full[k], obs_cnt[k]);
      end
    end
    repeat (3) step(6'b010111, 1'b1, 1'b0, 3'd2);
    step(6'b000000, 1'b0, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_rd[k] !== 3'b010 || obs_dup[k] !== 1'b1 || obs_cnt[k] !== 4'd8) begin
        n_err++;
        $display("FAIL fill_done dut%0d extra_word: got rd=%b dup=%0d cnt=%0d expected rd=010 dup=1 cnt=8",
                 k, obs_rd[k], obs_dup[k], obs_cnt[k]);
      end
      n_vec++;
      if (obs_vec[k] !== exp_vec(k)) begin
        n_err++;
        $display("FAIL fill_done dut%0d: got %b expected %b", k, obs_vec[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_duplicate();
    step(6'b000000, 1'b0, 1'b1, 3'd0);
    repeat (3) step(6'b010011, 1'b1, 1'b0, 3'd2);
    repeat (3) step(6'b010110, 1'b1, 1'b0, 3'd2);
    step(6'b000000, 1'b0, 1'b0, 3'd2);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_cnt[k] !== 4'd1 || obs_rd[k] !== 3'b110 || obs_dup[k] !== 1'b1) begin
        n_err++;
        $display("FAIL duplicate dut%0d: got cnt=%0d rd=%b dup=%0d expected cnt=1 rd=110 dup=1",
                 k, obs_cnt[k], obs_rd[k], obs_dup[k]);
      end
    end
  endtask

  task automatic test_clear_collision();
    repeat (3) step(6'b001111, 1'b1, 1'b1, 3'd1);
    step(6'b000000, 1'b0, 1'b0, 3'd1);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_cnt[k] !== 4'd0 || obs_rv[k] !== 1'b0 || obs_busy[k] !== 1'b0 ||
          obs_full[k] !== 1'b0 || obs_dup[k] !== 1'b0) begin
        n_err++;
        $display("FAIL clear_collision dut%0d: got %b expected cnt=0 rv=0 busy=0 full=0 dup=0", k, obs_vec[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] w;
    logic       v, c;
    w = 6'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) >= 60) w = 6'($urandom_range(0, 63));
      v = ($urandom_range(0, 99) < 85);
      c = ($urandom_range(0, 99) < 2);
      step(w, v, c, 3'($urandom_range(0, 7)));
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (obs_vec[k] !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random cycle%0d dut%0d: got %b expected %b", n, k, obs_vec[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(6'b000000, 1'b0, 1'b1, 3'd0);
    repeat (3) step(6'b001010, 1'b1, 1'b0, 3'd0);
    repeat (3) step(6'b011001, 1'b1, 1'b0, 3'd0);
    repeat (3) step(6'b101100, 1'b1, 1'b0, 3'd0);
    repeat (3) step(6'b111011, 1'b1, 1'b0, 3'd0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_cnt[k] !== 4'd4) begin
        n_err++;
        $display("FAIL async_reset pre_count dut%0d: got %0d expected 4", k, obs_cnt[k]);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_vec[k] !== 11'd0) begin
        n_err++;
        $display("FAIL async_reset immediate dut%0d: got %b expected 0", k, obs_vec[k]);
      end
    end
    model_reset();
    rst = 1'b1;
    step(6'b000000, 1'b0, 1'b0, 3'd3);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (obs_rd[k] !== 3'd0 || obs_rv[k] !== 1'b0) begin
        n_err++;
        $display("FAIL async_reset readback dut%0d: got %b/%b expected 000/0", k, obs_rd[k], obs_rv[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_single_capture();
    test_stability();
    test_fill_done();
    test_duplicate();
    test_clear_collision();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pe_word_collector.md
# pe_word_collector

Receiving end of the PE output link. Samples the `{addr, data}` word driven on a PE's `o_PE` bus and accepts a word only once it has stayed stable for `SORT_CYCLES` cycles. Each accepted word is written into a local register file indexed by its address field. The block tracks which addresses have been filled, flags duplicates, and reports completion. Stored words are read back through a registered port. It sits at the edge of the mesh, at the end of a row or in a bench harness, and turns PE output streams into an addressable result memory.

## Interface
- `ADDR_WIDTH`, 3, width of the address field; memory depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 3, width of the data field.
- `SORT_CYCLES`, 1, consecutive stable cycles required before capture; legal values ≥1.

- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_word`  in  ADDR_WIDTH+DATA_WIDTH  PE output word; address in the MSBs `[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]`, data in the LSBs.
- `i_valid`  in  1  `i_word` is meaningful this cycle.
- `i_clear`  in  1  synchronous clear of fill state, count and flags.
- `rd_addr`  in  ADDR_WIDTH  readback address.
- `rd_data`  out  DATA_WIDTH  registered readback data.
- `rd_valid`  out  1  registered fill bit for the address being read.
- `o_count`  out  ADDR_WIDTH+1  number of distinct addresses filled.
- `o_busy`  out  1  state is COLLECT.
- `o_full`  out  1  state is DONE.
- `o_dup`  out  1  sticky: a repeated address was captured, or a word arrived while in DONE.

## Operation
- **Reset.** Asserting `rst` low clears, immediately and asynchronously:
  - all memory entries, the filled bitmap, `o_count`, `o_dup`, `rd_data`, `rd_valid` and the stability counter;
  - the state, which returns to IDLE.
  - All outputs are 0 while `rst` is low.
- **Stability counter (`stab`).**
  - Increments each cycle that `i_valid` is 1 and `i_word` equals the previous cycle's `i_word`.
  - Loads 1 when `i_valid` is 1 and the word has changed, or `i_valid` was 0 the previous cycle.
  - Clears to 0 when `i_valid` is 0.
  - Saturates at `SORT_CYCLES`.
- **Capture.** Fires in the cycle where `stab` would reach `SORT_CYCLES`. Exactly one capture per stable run; no recapture until `i_valid` drops or the word changes.
- **Capture effects:**
  - `mem[addr] <= data` and `filled[addr] <= 1`.
  - If the address was not yet filled, `o_count` increments.
  - If the address was already filled, data is overwritten, `o_count` is unchanged and `o_dup` sets.
- **State machine:**
  - IDLE: `o_count` = 0. The first capture moves to COLLECT, or straight to DONE when 2^ADDR_WIDTH = 1.
  - COLLECT: a capture that brings `o_count` to 2^ADDR_WIDTH moves to DONE.
  - DONE: captures are ignored (memory untouched) and `o_dup` sets. Only `i_clear` or `rst` leaves DONE.
- **Clear.** `i_clear` = 1 clears the filled bitmap, `o_count`, `o_dup` and `stab`, and returns to IDLE. Memory contents are retained.
  - Clear beats a capture in the same cycle; that capture is dropped.
- **Readback.** `rd_data <= mem[rd_addr]` and `rd_valid <= filled[rd_addr]` every cycle.
  - Reading an address that is being written in the same cycle returns the old value (read-before-write).

## Timing
- **Capture latency.** With `SORT_CYCLES` = S, a word first presented valid at edge k is written at edge k+S-1.
  - `o_count`, `o_busy`, `o_full` and `o_dup` update at that same edge.
  - For S = 1, capture happens in the first valid cycle.
- **Read latency.** 1 cycle from `rd_addr` to `rd_data`/`rd_valid`.
- **Clear timing.** `i_clear` takes effect at the next edge; `o_full` drops in that cycle.
- **Counter width.** `o_count` is ADDR_WIDTH+1 bits and never wraps: its maximum is 2^ADDR_WIDTH, held in DONE.
- **Reset mid-operation.** A partial stability run is discarded; no capture occurs on the edge at which `rst` is released.

## Test plan
- **Single capture.** S = 1, reset released, `i_word` = 000101 valid for 1 cycle → `o_count` = 1, `o_busy` = 1. Then `rd_addr` = 000 → next cycle `rd_data` = 101, `rd_valid` = 1.
- **Stability filter.** S = 3: word 011110 held valid 2 cycles, then changed to 100001 → no capture. Hold 100001 for 3 cycles → `o_count` = 1 and readback of address 100 = 001.
- **Fill to DONE.** S = 1, addresses 0–7 with data = addr → `o_full` = 1 and `o_count` = 8 after the 8th capture. A further word 010111 → memory[2] stays 010, `o_dup` = 1, `o_count` = 8.
- **Duplicate address.** Capture 010011, then 010110 → `o_count` = 1, readback of address 010 = 110, `o_dup` = 1.
- **Clear collision.** `i_clear` asserted in the same cycle as a capture of 001111 → `o_count` = 0, `rd_valid` of address 001 = 0, state IDLE, `o_dup` = 0.
- **Async reset mid-run.** After 4 captures, drive `rst` low between edges → all outputs 0 immediately. After release, first readback gives `rd_data` = 0, `rd_valid` = 0.
